calc_client: RTL
================

Name: calc_client

Overview:
- Command-side initiator for the team's registered 8-bit calculator block.
- Accepts tagged arithmetic commands over a valid/ready stream and drives the calculator's op/num1/num2 inputs.
- Captures the calculator's registered result after a fixed latency and returns it over a valid/ready response stream, with overflow and divide-by-zero flags computed locally.
- Keeps running response and error counters for status readback.

Parameters:
TAG_W, 4, width of command/response tag
CALC_LAT, 1, calculator result latency in cycles (>=1); 1 matches the single-register calculator
CNT_W, 16, width of op_count and err_count

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  block can accept a command
cmd_op  in  2  00 add, 01 sub, 10 mul, 11 div
cmd_a  in  8  operand A (num1)
cmd_b  in  8  operand B (num2)
cmd_tag  in  TAG_W  opaque tag echoed on response
calc_op  out  2  to calculator op
calc_num1  out  8  to calculator num1
calc_num2  out  8  to calculator num2
calc_result  in  8  from calculator result
calc_valid  in  1  from calculator valid
resp_valid  out  1  response present
resp_ready  in  1  consumer accepts response
resp_data  out  8  result (low 8 bits)
resp_tag  out  TAG_W  tag of the originating command
resp_ovf  out  1  result did not fit in 8 bits
resp_err  out  1  divide by zero; calculator not used
op_count  out  CNT_W  completed response handshakes, wraps
err_count  out  CNT_W  responses with resp_err=1, saturates at all-ones

Behaviour:
- Reset (rst=1 at a clock edge) forces all outputs to 0 on the following cycle, except cmd_ready=1 (IDLE).
  - Outputs at 0: resp_valid, resp_data, resp_tag, resp_ovf, resp_err, calc_op, calc_num1, calc_num2, op_count, err_count.
  - Reset mid-operation (any state) abandons the in-flight command; no response is issued.
- States:
  - IDLE: cmd_ready=1. On cmd_valid&cmd_ready, latch op/a/b/tag.
    - If op=11 and b=0: go to RESP with resp_data=8'hFF, resp_err=1, resp_ovf=0. calc_* are unchanged.
    - Otherwise: load calc_op/calc_num1/calc_num2 from the command, compute ovf, and go to ISSUE.
  - ISSUE: calc_* held stable for CALC_LAT cycles (internal down-counter), then go to CAPTURE.
  - CAPTURE: if calc_valid=1, register calc_result into resp_data and go to RESP. If calc_valid=0 (calculator still in reset), remain in CAPTURE with calc_* held.
  - RESP: resp_valid=1. resp_data, resp_tag, resp_ovf and resp_err stay stable until resp_valid&resp_ready; then go to IDLE.
- cmd_ready=0 in every state except IDLE; at most one command is in flight.
- Latency, accept edge to first resp_valid cycle:
  - Normal op: CALC_LAT+2 cycles (3 at default).
  - Divide by zero: 1 cycle.
- Overflow rules (computed from the latched operands):
  - add: 9-bit sum > 255.
  - sub: a < b; result wraps mod 256.
  - mul: 16-bit product > 255; resp_data is the low 8 bits.
  - div with b != 0: never overflows.
- resp_data always comes from calc_result; the block does not compute results itself.
- calc_* outputs hold their last values in IDLE and RESP.
- Counters update on the response handshake:
  - op_count += 1 on every handshake, including error responses; wraps to 0.
  - err_count += 1 when resp_err=1; saturates at all-ones.
- When resp_ready is held high, a response completes in its first cycle. The next command can be accepted one cycle later, in IDLE.

Test Plan:
- add a=200 b=100 tag=3 -> calc_op=00, calc_num1=200, calc_num2=100 for one cycle; resp_valid 3 cycles after accept with resp_data=44, resp_ovf=1, resp_err=0, resp_tag=3; op_count=1.
- sub a=5 b=7 -> resp_data=254, resp_ovf=1. Then sub a=9 b=4 -> resp_data=5, resp_ovf=0.
- mul a=16 b=16 -> resp_data=0, resp_ovf=1. Then mul a=15 b=17 -> resp_data=255, resp_ovf=0.
- div a=100 b=0 -> resp_valid 1 cycle after accept, resp_data=8'hFF, resp_err=1, calc_* unchanged, err_count=1. Then div a=100 b=7 -> resp_data=14, resp_err=0.
- Backpressure: resp_ready=0 for 5 cycles during RESP -> resp_valid, resp_data and resp_tag stable; cmd_ready=0 while cmd_valid is held high; no second accept until 1 cycle after the handshake.
- Reset during ISSUE, and separately during RESP -> next cycle: resp_valid=0, cmd_ready=1, counters=0, calc_*=0. A subsequent add 1+1 returns resp_data=2 with op_count=1.

Source files
------------

// File: rtl/calc_client.sv
// Command-side initiator for the registered 8-bit calculator: issues one tagged
// command at a time, captures the calculator result and returns it with flags.
module calc_client #(
    parameter int TAG_W    = 4,
    parameter int CALC_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [7:0]       cmd_a,
    input  logic [7:0]       cmd_b,
    input  logic [TAG_W-1:0] cmd_tag,
    output logic [1:0]       calc_op,
    output logic [7:0]       calc_num1,
    output logic [7:0]       calc_num2,
    input  logic [7:0]       calc_result,
    input  logic             calc_valid,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [7:0]       resp_data,
    output logic [TAG_W-1:0] resp_tag,
    output logic             resp_ovf,
    output logic             resp_err,
    output logic [CNT_W-1:0] op_count,
    output logic [CNT_W-1:0] err_count
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ISSUE   = 2'd1;
    localparam logic [1:0] CAPTURE = 2'd2;
    localparam logic [1:0] RESP    = 2'd3;

    localparam int LAT_W = (CALC_LAT > 1) ? $clog2(CALC_LAT) : 1;
    localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(CALC_LAT - 1);

    logic [1:0]       state;
    logic [LAT_W-1:0] lat_cnt;
    logic [8:0]       sum;
    logic [15:0]      prod;
    logic             div_zero;
    logic             ovf_next;

    assign cmd_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);

    // Overflow is judged from the operands so the calculator itself stays untouched.
    always_comb begin
        sum      = {1'b0, cmd_a} + {1'b0, cmd_b};
        prod     = 16'(cmd_a) * 16'(cmd_b);
        div_zero = (cmd_op == 2'b11) && (cmd_b == 8'd0);
        ovf_next = 1'b0;
        case (cmd_op)
            2'b00:   ovf_next = sum[8];
            2'b01:   ovf_next = (cmd_a < cmd_b);
            2'b10:   ovf_next = (prod[15:8] != 8'd0);
            default: ovf_next = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            lat_cnt   <= '0;
            calc_op   <= '0;
            calc_num1 <= '0;
            calc_num2 <= '0;
            resp_data <= '0;
            resp_tag  <= '0;
            resp_ovf  <= 1'b0;
            resp_err  <= 1'b0;
            op_count  <= '0;
            err_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        resp_tag <= cmd_tag;
                        if (div_zero) begin
                            resp_data <= 8'hFF;
                            resp_err  <= 1'b1;
                            resp_ovf  <= 1'b0;
                            state     <= RESP;
                        end else begin
                            calc_op   <= cmd_op;
                            calc_num1 <= cmd_a;
                            calc_num2 <= cmd_b;
                            resp_ovf  <= ovf_next;
                            resp_err  <= 1'b0;
                            lat_cnt   <= LAT_INIT;
                            state     <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (lat_cnt == '0) begin
                        state <= CAPTURE;
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end
                // calc_valid low means the calculator is held in reset; keep waiting.
                CAPTURE: begin
                    if (calc_valid) begin
                        resp_data <= calc_result;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        state    <= IDLE;
                        op_count <= op_count + CNT_W'(1);
                        if (resp_err && (err_count != {CNT_W{1'b1}})) begin
                            err_count <= err_count + CNT_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
